// File: rtl/data_ram_responder_if.sv
// MEM-stage data-port bundle between the requester (master) and the RAM responder (slave).
interface data_ram_responder_if;
    logic        ram_en;
    logic [3:0]  ram_write_en;
    logic [31:0] ram_addr;
    logic [31:0] ram_write_data;
    logic        stall_current_stage;
    logic [31:0] ram_read_data;
    logic        stall_request;

    modport master (
        output ram_en, ram_write_en, ram_addr, ram_write_data, stall_current_stage,
        input  ram_read_data, stall_request
    );

    modport slave (
        input  ram_en, ram_write_en, ram_addr, ram_write_data, stall_current_stage,
        output ram_read_data, stall_request
    );
endinterface

// File: rtl/data_ram_responder.sv
// Data-memory responder: word-organised RAM answering MEM-stage loads/stores with the full word.
// Define DATA_RAM_WAIT_EN to add WAIT_CYCLES wait states with stall_request / stall_current_stage handshaking.
module data_ram_responder #(
    parameter int unsigned ADDR_WIDTH  = 10,
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    data_ram_responder_if.slave  bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

    logic [31:0]           mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] idx;

    // High address bits alias onto the array; byte offset is handled downstream.
    assign idx = bus.ram_addr[ADDR_WIDTH+1:2];

`ifdef DATA_RAM_WAIT_EN
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [3:0]            cnt_q;
    logic [31:0]           resp_q;
    logic [31:0]           wr_data_q;
    logic [3:0]            wr_be_q;
    logic [ADDR_WIDTH-1:0] wr_idx_q;
    logic [31:0]           wr_word_d;
    logic                  unused_ok;

    assign unused_ok = ^{bus.ram_addr[31:ADDR_WIDTH+2], bus.ram_addr[1:0]};

    always_comb begin
        wr_word_d = mem_q[wr_idx_q];
        for (int unsigned i = 0; i < 4; i++) begin
            if (wr_be_q[i]) begin
                wr_word_d[8*i +: 8] = wr_data_q[8*i +: 8];
            end
        end
    end

    // The store is captured with the read data so the commit on DONE exit returns the pre-write word.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            resp_q    <= '0;
            wr_be_q   <= '0;
            wr_data_q <= '0;
            wr_idx_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.ram_en) begin
                        if (WAIT_CYCLES == 0) begin
                            state_q   <= S_DONE;
                            resp_q    <= mem_q[idx];
                            wr_be_q   <= bus.ram_write_en;
                            wr_data_q <= bus.ram_write_data;
                            wr_idx_q  <= idx;
                        end else begin
                            state_q <= S_WAIT;
                            cnt_q   <= 4'(WAIT_CYCLES - 1);
                        end
                    end
                end
                S_WAIT: begin
                    if (!bus.ram_en) begin
                        state_q <= S_IDLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == '0) begin
                        state_q   <= S_DONE;
                        resp_q    <= mem_q[idx];
                        wr_be_q   <= bus.ram_write_en;
                        wr_data_q <= bus.ram_write_data;
                        wr_idx_q  <= idx;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_DONE: begin
                    if (!bus.stall_current_stage) begin
                        state_q <= S_IDLE;
                        resp_q  <= '0;
                        wr_be_q <= '0;
                        if (wr_be_q != '0) begin
                            mem_q[wr_idx_q] <= wr_word_d;
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.stall_request = !rst && (((state_q == S_IDLE) && bus.ram_en) || (state_q == S_WAIT));
    assign bus.ram_read_data = (!rst && (state_q == S_DONE)) ? resp_q : '0;
`else
    logic [31:0] wr_word_d;
    logic        unused_ok;

    assign unused_ok = ^{bus.ram_addr[31:ADDR_WIDTH+2], bus.ram_addr[1:0],
                         bus.stall_current_stage, 1'(WAIT_CYCLES)};

    always_comb begin
        wr_word_d = mem_q[idx];
        for (int unsigned i = 0; i < 4; i++) begin
            if (bus.ram_write_en[i]) begin
                wr_word_d[8*i +: 8] = bus.ram_write_data[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.ram_en && (bus.ram_write_en != '0)) begin
            mem_q[idx] <= wr_word_d;
        end
    end

    assign bus.stall_request = 1'b0;
    assign bus.ram_read_data = (!rst && bus.ram_en) ? mem_q[idx] : '0;
`endif
endmodule

// File: tb/tb_data_ram_responder.sv
// Directed bench for data_ram_responder; wait-state scenarios compile in with DATA_RAM_WAIT_EN.
module tb_data_ram_responder;
    localparam int unsigned AW = 10;
    localparam int unsigned WC = 2;
`ifdef DATA_RAM_WAIT_EN
    localparam int EXP_STALL = WC + 1;
`else
    localparam int EXP_STALL = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    data_ram_responder_if bus ();

    data_ram_responder #(
        .ADDR_WIDTH  (AW),
        .WAIT_CYCLES (WC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Drives one request from just after a rising edge and returns what was observed.
    task automatic access(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd,
                          input int hold, output logic [31:0] rd, output logic [31:0] rd_held,
                          output int stalls, output int dirty);
        bus.ram_en         = 1'b1;
        bus.ram_addr       = a;
        bus.ram_write_en   = be;
        bus.ram_write_data = wd;
        stalls = 0;
        dirty  = 0;
        @(negedge clk);
        while (bus.stall_request === 1'b1 && stalls < 64) begin
            stalls++;
            if (bus.ram_read_data !== 32'h0) dirty++;
            @(negedge clk);
        end
        rd      = bus.ram_read_data;
        rd_held = rd;
        if (hold > 0) begin
            bus.stall_current_stage = 1'b1;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                rd_held = bus.ram_read_data;
            end
            bus.stall_current_stage = 1'b0;
        end
        @(posedge clk);
        #1;
        bus.ram_en       = 1'b0;
        bus.ram_write_en = 4'h0;
    endtask

    task automatic test_reset();
        bus.ram_en = 1'b1;
        bus.ram_addr = 32'h40;
        bus.ram_write_en = 4'h0;
        bus.ram_write_data = 32'h0;
        bus.stall_current_stage = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.ram_read_data !== 32'h0) begin
            errors++; $display("FAIL reset_rdata: got %h expected %h", bus.ram_read_data, 32'h0);
        end
        checks++;
        if (bus.stall_request !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", bus.stall_request);
        end
        bus.ram_en = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ram_read_data !== 32'h0) begin
            errors++; $display("FAIL idle_rdata: got %h expected %h", bus.ram_read_data, 32'h0);
        end
        checks++;
        if (bus.stall_request !== 1'b0) begin
            errors++; $display("FAIL idle_stall: got %b expected 0", bus.stall_request);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_zero_wait();
        logic [31:0] rd, rh;
        int st, dt;
        access(32'h40, 4'hF, 32'hDEADBEEF, 0, rd, rh, st, dt);
        checks++;
        if (st != EXP_STALL) begin
            errors++; $display("FAIL write_stall_cycles: got %0d expected %0d", st, EXP_STALL);
        end
        access(32'h40, 4'h0, 32'h0, 0, rd, rh, st, dt);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL read_40: got %h expected %h", rd, 32'hDEADBEEF);
        end
        checks++;
        if (st != EXP_STALL) begin
            errors++; $display("FAIL read_stall_cycles: got %0d expected %0d", st, EXP_STALL);
        end
    endtask

    task automatic test_byte_lanes();
        logic [31:0] rd, rh;
        int st, dt;
        access(32'h8, 4'hF, 32'h11223344, 0, rd, rh, st, dt);
        access(32'h8, 4'b0010, 32'h0000AB00, 0, rd, rh, st, dt);
        checks++;
        if (rd !== 32'h11223344) begin
            errors++; $display("FAIL write_returns_old: got %h expected %h", rd, 32'h11223344);
        end
        access(32'h8, 4'h0, 32'h0, 0, rd, rh, st, dt);
        checks++;
        if (rd !== 32'h1122AB44) begin
            errors++; $display("FAIL lane1: got %h expected %h", rd, 32'h1122AB44);
        end
        access(32'h8, 4'b1001, 32'hCC0000DD, 0, rd, rh, st, dt);
        access(32'h8, 4'h0, 32'h0, 0, rd, rh, st, dt);
        checks++;
        if (rd !== 32'hCC22ABDD) begin
            errors++; $display("FAIL lanes03: got %h expected %h", rd, 32'hCC22ABDD);
        end
    endtask

    task automatic test_alias();
        logic [31:0] rd, rh;
        int st, dt;
        access(32'h1000, 4'hF, 32'h5, 0, rd, rh, st, dt);
        access(32'h0, 4'h0, 32'h0, 0, rd, rh, st, dt);
        checks++;
        if (rd !== 32'h5) begin
            errors++; $display("FAIL alias_1000: got %h expected %h", rd, 32'h5);
        end
        access(32'hFFFFF00E, 4'hF, 32'h77, 0, rd, rh, st, dt);
        access(32'hC, 4'h0, 32'h0, 0, rd, rh, st, dt);
        checks++;
        if (rd !== 32'h77) begin
            errors++; $display("FAIL alias_high: got %h expected %h", rd, 32'h77);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd, rh;
        logic [31:0] exp_v [3];
        logic [31:0] addr_v [3];
        int st, dt;
        exp_v  = '{32'hDEADBEEF, 32'hCC22ABDD, 32'h5};
        addr_v = '{32'h40, 32'h8, 32'h0};
        for (int i = 0; i < 3; i++) begin
            access(addr_v[i], 4'h0, 32'h0, 0, rd, rh, st, dt);
            checks++;
            if (rd !== exp_v[i]) begin
                errors++; $display("FAIL b2b_%0d: got %h expected %h", i, rd, exp_v[i]);
            end
        end
    endtask

`ifdef DATA_RAM_WAIT_EN
    task automatic test_wait_timing();
        logic [31:0] rd, rh;
        int st, dt;
        access(32'h40, 4'h0, 32'h0, 0, rd, rh, st, dt);
        checks++;
        if (st != WC + 1) begin
            errors++; $display("FAIL wait_stall_len: got %0d expected %0d", st, WC + 1);
        end
        checks++;
        if (dt != 0) begin
            errors++; $display("FAIL wait_rdata_zero: got %0d nonzero cycles expected 0", dt);
        end
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL wait_done_data: got %h expected %h", rd, 32'hDEADBEEF);
        end
    endtask

    task automatic test_hold();
        logic [31:0] rd, rh;
        int st, dt;
        access(32'h40, 4'hF, 32'h12345678, 3, rd, rh, st, dt);
        checks++;
        if (rd !== 32'hDEADBEEF) begin
            errors++; $display("FAIL hold_first: got %h expected %h", rd, 32'hDEADBEEF);
        end
        checks++;
        if (rh !== 32'hDEADBEEF) begin
            errors++; $display("FAIL hold_last: got %h expected %h", rh, 32'hDEADBEEF);
        end
        access(32'h40, 4'h0, 32'h0, 0, rd, rh, st, dt);
        checks++;
        if (rd !== 32'h12345678) begin
            errors++; $display("FAIL hold_commit: got %h expected %h", rd, 32'h12345678);
        end
    endtask

    task automatic test_abort();
        logic [31:0] rd, rh;
        int st, dt;
        bus.ram_en = 1'b1;
        bus.ram_addr = 32'h40;
        bus.ram_write_en = 4'hF;
        bus.ram_write_data = 32'hAAAAAAAA;
        @(posedge clk); #1;
        bus.ram_en = 1'b0;
        bus.ram_write_en = 4'h0;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.stall_request !== 1'b0) begin
            errors++; $display("FAIL abort_stall: got %b expected 0", bus.stall_request);
        end
        @(posedge clk); #1;
        access(32'h40, 4'h0, 32'h0, 0, rd, rh, st, dt);
        checks++;
        if (rd !== 32'h12345678) begin
            errors++; $display("FAIL abort_nowrite: got %h expected %h", rd, 32'h12345678);
        end
    endtask
`endif

    task automatic test_reset_mid();
        logic [31:0] rd, rh;
        int st, dt;
        bus.ram_en = 1'b1;
        bus.ram_addr = 32'h8;
        bus.ram_write_en = 4'hF;
        bus.ram_write_data = 32'h55;
`ifdef DATA_RAM_WAIT_EN
        @(posedge clk); #1;
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        checks++;
        if (bus.ram_read_data !== 32'h0) begin
            errors++; $display("FAIL rstmid_rdata: got %h expected %h", bus.ram_read_data, 32'h0);
        end
        checks++;
        if (bus.stall_request !== 1'b0) begin
            errors++; $display("FAIL rstmid_stall: got %b expected 0", bus.stall_request);
        end
        bus.ram_en = 1'b0;
        bus.ram_write_en = 4'h0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.ram_read_data !== 32'h0 || bus.stall_request !== 1'b0) begin
            errors++; $display("FAIL rstmid_idle: got rdata %h stall %b expected 0 and 0",
                               bus.ram_read_data, bus.stall_request);
        end
        @(posedge clk); #1;
        access(32'h8, 4'h0, 32'h0, 0, rd, rh, st, dt);
        checks++;
        if (rd !== 32'hCC22ABDD) begin
            errors++; $display("FAIL rstmid_unchanged: got %h expected %h", rd, 32'hCC22ABDD);
        end
    endtask

    initial begin
        bus.ram_en = 1'b0;
        bus.ram_addr = 32'h0;
        bus.ram_write_en = 4'h0;
        bus.ram_write_data = 32'h0;
        bus.stall_current_stage = 1'b0;
        test_reset();
        test_zero_wait();
        test_byte_lanes();
        test_alias();
        test_back_to_back();
`ifdef DATA_RAM_WAIT_EN
        test_wait_timing();
        test_hold();
        test_abort();
`endif
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
